// File: rtl/alu_md.sv
// alu_md: EX-stage execute unit. A single-cycle integer ALU plus an iterative
// multiply/divide engine that owns the architectural HI/LO registers.
//
// Handshake: a sequential op (ALUop 1000..1011) is accepted on a rising edge
// where start=1 and the engine is idle; requests at any other time are dropped.
// mult/div then hold busy=1 for exactly WIDTH cycles, and done pulses for one
// cycle afterwards with hi/lo already holding the new values. mthi/mtlo write
// hi/lo at the accepting edge and never raise busy or done.
module alu_md #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] ope1,
  input  logic [WIDTH-1:0] ope2,
  input  logic [3:0]       ALUop,
  input  logic             ALUsign,
  input  logic             start,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  // Current FSM state, visible by name for assertions and probes.
  state_t state_q, state_d;

  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] acc_hi_q;   // mult: upper partial product / div: remainder
  logic [WIDTH-1:0] acc_lo_q;   // mult: multiplier bits      / div: quotient
  logic [WIDTH-1:0] opnd_q;     // mult: multiplicand         / div: divisor
  logic             is_div_q;
  logic             neg_q_q;    // negate product / quotient at the end
  logic             neg_r_q;    // negate remainder at the end

  // ---------------------------------------------------------------------------
  // Combinational ALU
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] add_res, sub_res;
  logic             add_ovf, sub_ovf, slt_bit;

  assign add_res = ope1 + ope2;
  assign sub_res = ope1 - ope2;
  assign add_ovf = (ope1[WIDTH-1] == ope2[WIDTH-1]) && (add_res[WIDTH-1] != ope1[WIDTH-1]);
  assign sub_ovf = (ope1[WIDTH-1] != ope2[WIDTH-1]) && (sub_res[WIDTH-1] != ope1[WIDTH-1]);
  assign slt_bit = ALUsign ? ($signed(ope1) < $signed(ope2)) : (ope1 < ope2);

  // Result mux: every op code drives a value, sequential codes read as zero.
  always_comb begin
    result   = '0;
    overflow = 1'b0;
    case (ALUop)
      4'b0000: begin result = add_res; overflow = ALUsign & add_ovf; end
      4'b0001: begin result = sub_res; overflow = ALUsign & sub_ovf; end
      4'b0010: result = ope1 | ope2;
      4'b0011: result = {{(WIDTH-1){1'b0}}, slt_bit};
      4'b0100: result = ope1 & ope2;
      4'b0101: result = ope1 ^ ope2;
      4'b0110: result = ~(ope1 | ope2);
      4'b1100: result = hi;
      4'b1101: result = lo;
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

  // ---------------------------------------------------------------------------
  // Multiply / divide engine
  // ---------------------------------------------------------------------------
  logic             accept;
  logic             last;
  logic             a_neg, b_neg, div_zero;
  logic [WIDTH-1:0] a_mag, b_mag;

  assign accept   = start && (state_q == IDLE) && (ALUop[3:2] == 2'b10);
  assign last     = (state_q == RUN) && (cnt_q == CNT_W'(WIDTH - 1));
  assign a_neg    = ALUsign & ope1[WIDTH-1];
  assign b_neg    = ALUsign & ope2[WIDTH-1];
  assign a_mag    = a_neg ? (~ope1 + 1'b1) : ope1;
  assign b_mag    = b_neg ? (~ope2 + 1'b1) : ope2;
  assign div_zero = (ope2 == '0);

  logic [WIDTH:0]   msum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] step_hi, step_lo;
  logic [2*WIDTH-1:0] prod, prod_fix;

  // One iteration: shift-add for mult, restoring shift-subtract for div.
  always_comb begin
    msum    = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : '0);
    shifted = {acc_hi_q, acc_lo_q[WIDTH-1]};
    diff    = shifted - {1'b0, opnd_q};
    step_hi = '0;
    step_lo = '0;
    if (is_div_q) begin
      if (!diff[WIDTH]) begin
        step_hi = diff[WIDTH-1:0];
        step_lo = {acc_lo_q[WIDTH-2:0], 1'b1};
      end else begin
        step_hi = shifted[WIDTH-1:0];
        step_lo = {acc_lo_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      step_hi = msum[WIDTH:1];
      step_lo = {msum[0], acc_lo_q[WIDTH-1:1]};
    end
    prod     = {step_hi, step_lo};
    prod_fix = neg_q_q ? (~prod + 1'b1) : prod;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // FSM next state: idle until a mult/div is accepted, run for WIDTH steps.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept && !ALUop[1]) state_d = RUN;
      RUN:  if (last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath registers, HI/LO write-back and the done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q    <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      opnd_q   <= '0;
      is_div_q <= 1'b0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      done     <= 1'b0;
    end else begin
      done <= last;
      if (state_q == IDLE) begin
        if (accept) begin
          case (ALUop[1:0])
            2'b00: begin
              cnt_q    <= '0;
              acc_hi_q <= '0;
              acc_lo_q <= b_mag;
              opnd_q   <= a_mag;
              is_div_q <= 1'b0;
              neg_q_q  <= a_neg ^ b_neg;
              neg_r_q  <= 1'b0;
            end
            2'b01: begin
              // Divide by zero runs the plain magnitude path on the raw
              // dividend, which leaves all ones in lo and ope1 in hi.
              cnt_q    <= '0;
              acc_hi_q <= '0;
              acc_lo_q <= div_zero ? ope1 : a_mag;
              opnd_q   <= b_mag;
              is_div_q <= 1'b1;
              neg_q_q  <= !div_zero && (a_neg ^ b_neg);
              neg_r_q  <= !div_zero && a_neg;
            end
            2'b10: hi <= ope1;
            default: lo <= ope1;
          endcase
        end
      end else begin
        cnt_q    <= cnt_q + 1'b1;
        acc_hi_q <= step_hi;
        acc_lo_q <= step_lo;
        if (last) begin
          if (is_div_q) begin
            hi <= neg_r_q ? (~step_hi + 1'b1) : step_hi;
            lo <= neg_q_q ? (~step_lo + 1'b1) : step_lo;
          end else begin
            hi <= prod_fix[2*WIDTH-1:WIDTH];
            lo <= prod_fix[WIDTH-1:0];
          end
        end
      end
    end
  end

  assign busy = (state_q == RUN);

endmodule

// File: tb/tb_alu_md.sv
// tb_alu_md: self-checking bench for alu_md (WIDTH=32) with a behavioural
// reference model built on plain integer arithmetic.
module tb_alu_md;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic [W-1:0]  ope1, ope2;
  logic [3:0]    ALUop;
  logic          ALUsign;
  logic          start;
  logic [W-1:0]  result;
  logic          zero, overflow, busy, done;
  logic [W-1:0]  hi, lo;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [W-1:0] model_hi = '0;
  logic [W-1:0] model_lo = '0;

  alu_md #(.WIDTH(W), .CNT_W(6)) dut (
    .clk(clk), .reset(reset), .ope1(ope1), .ope2(ope2), .ALUop(ALUop),
    .ALUsign(ALUsign), .start(start), .result(result), .zero(zero),
    .overflow(overflow), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic void model_md(input logic [3:0] op, input logic [W-1:0] a, b,
                                   input logic s, output logic [W-1:0] eh, el);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = s ? longint'($signed(a)) : longint'({32'b0, a});
    sb = s ? longint'($signed(b)) : longint'({32'b0, b});
    eh = model_hi;
    el = model_lo;
    case (op)
      4'b1000: begin p = 64'(sa * sb); eh = p[63:32]; el = p[31:0]; end
      4'b1001: begin
        if (b == '0) begin el = '1; eh = a; end
        else begin q = sa / sb; r = sa % sb; el = q[31:0]; eh = r[31:0]; end
      end
      4'b1010: eh = a;
      4'b1011: el = a;
      default: ;
    endcase
  endfunction

  function automatic void model_alu(input logic [3:0] op, input logic [W-1:0] a, b,
                                    input logic s, output logic [W-1:0] er, output logic eo);
    longint sa, sb, t;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    er = '0;
    eo = 1'b0;
    case (op)
      4'b0000: begin er = a + b; t = sa + sb; eo = s && (t > 64'sd2147483647 || t < -64'sd2147483648); end
      4'b0001: begin er = a - b; t = sa - sb; eo = s && (t > 64'sd2147483647 || t < -64'sd2147483648); end
      4'b0010: er = a | b;
      4'b0011: er = (s ? (sa < sb) : (a < b)) ? 32'd1 : 32'd0;
      4'b0100: er = a & b;
      4'b0101: er = a ^ b;
      4'b0110: er = ~(a | b);
      4'b1100: er = model_hi;
      4'b1101: er = model_lo;
      default: er = '0;
    endcase
  endfunction

  // ---------------- driver ----------------
  // Called one step after a rising edge. Issues a one-cycle start, scrambles
  // the operands during the run, reads mfhi in the first busy cycle and
  // returns once busy falls (bounded), sampled in the done cycle.
  task automatic do_seq(input logic [3:0] op, input logic [W-1:0] a, b, input logic s,
                        output int bcnt, output logic [W-1:0] run_res);
    ALUop = op; ope1 = a; ope2 = b; ALUsign = s; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; ope1 = $urandom; ope2 = $urandom; ALUop = 4'b1100;
    #1 run_res = result;
    bcnt = 0;
    while (busy && bcnt < 200) begin
      bcnt++;
      @(posedge clk); #1;
    end
    ALUop = 4'b1110;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1; start = 1'b0; ope1 = '0; ope2 = '0; ALUop = 4'b1100; ALUsign = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total_cnt++;
    if ({busy, done, hi, lo} !== '0) $display("FAIL reset_state busy=%b done=%b hi=%h lo=%h required all 0", busy, done, hi, lo);
    else pass_cnt++;
    total_cnt++;
    if (result !== '0 || zero !== 1'b1) $display("FAIL reset_mfhi result=%h zero=%b required 0/1", result, zero);
    else pass_cnt++;
    reset = 1'b0;
    model_hi = '0; model_lo = '0;
  endtask

  task automatic test_add_overflow();
    ope1 = 32'h7FFFFFFF; ope2 = 32'h1; ALUop = 4'b0000; ALUsign = 1'b1;
    #1;
    total_cnt++;
    if (result !== 32'h80000000 || overflow !== 1'b1 || zero !== 1'b0)
      $display("FAIL add_ovf_signed result=%h ovf=%b zero=%b required 80000000/1/0", result, overflow, zero);
    else pass_cnt++;
    ALUsign = 1'b0;
    #1;
    total_cnt++;
    if (result !== 32'h80000000 || overflow !== 1'b0)
      $display("FAIL add_ovf_unsigned result=%h ovf=%b required 80000000/0", result, overflow);
    else pass_cnt++;
    ope1 = 32'h80000000; ope2 = 32'h1; ALUop = 4'b0001; ALUsign = 1'b1;
    #1;
    total_cnt++;
    if (result !== 32'h7FFFFFFF || overflow !== 1'b1)
      $display("FAIL sub_ovf result=%h ovf=%b required 7fffffff/1", result, overflow);
    else pass_cnt++;
  endtask

  task automatic test_alu_random();
    logic [3:0] ops[12] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd11, 4'd12, 4'd13, 4'd15};
    logic [W-1:0] er;
    logic eo;
    for (int i = 0; i < 60; i++) begin
      ALUop = ops[$urandom_range(0, 11)];
      ALUsign = 1'($urandom_range(0, 1));
      ope1 = $urandom;
      ope2 = (i % 7 == 0) ? ope1 : $urandom;
      if (i % 5 == 0) ope2 = {~ope1[31], ope1[30:0]};
      #1;
      model_alu(ALUop, ope1, ope2, ALUsign, er, eo);
      total_cnt++;
      if (result !== er || overflow !== eo || zero !== (er == '0))
        $display("FAIL alu_op%0d a=%h b=%h s=%b result=%h ovf=%b zero=%b required %h/%b/%b",
                 ALUop, ope1, ope2, ALUsign, result, overflow, zero, er, eo, er == '0);
      else pass_cnt++;
    end
    ALUop = 4'b1110;
  endtask

  task automatic test_seq_fixed(input logic [3:0] op, input logic [W-1:0] a, b, input logic s);
    int bc;
    logic [W-1:0] rr, eh, el, old_hi;
    old_hi = model_hi;
    model_md(op, a, b, s, eh, el);
    @(posedge clk); #1;
    do_seq(op, a, b, s, bc, rr);
    model_hi = eh; model_lo = el;
    total_cnt++;
    if (rr !== old_hi) $display("FAIL mfhi_during_run op%0d result=%h required %h", op, rr, old_hi);
    else pass_cnt++;
    total_cnt++;
    if (bc !== W) $display("FAIL busy_len op%0d cycles=%0d required %0d", op, bc, W);
    else pass_cnt++;
    total_cnt++;
    if (done !== 1'b1 || hi !== eh || lo !== el)
      $display("FAIL seq_result op%0d a=%h b=%h s=%b done=%b hi=%h lo=%h required 1/%h/%h", op, a, b, s, done, hi, lo, eh, el);
    else pass_cnt++;
    @(posedge clk); #1;
    ALUop = 4'b1101;
    #1;
    total_cnt++;
    if (done !== 1'b0 || result !== el) $display("FAIL done_pulse_mflo op%0d done=%b result=%h required 0/%h", op, done, result, el);
    else pass_cnt++;
    ALUop = 4'b1110;
  endtask

  task automatic test_seq_random();
    int bc;
    logic [W-1:0] rr, eh, el, a, b;
    logic [3:0] op;
    logic s;
    for (int i = 0; i < 16; i++) begin
      op = 4'b1000 | 4'($urandom_range(0, 1));
      s = 1'($urandom_range(0, 1));
      a = $urandom;
      b = (i % 4 == 3) ? 32'($urandom_range(1, 9)) : $urandom;
      if (i == 5) begin a = 32'h80000000; b = 32'hFFFFFFFF; op = 4'b1001; s = 1'b1; end
      model_md(op, a, b, s, eh, el);
      @(posedge clk); #1;
      do_seq(op, a, b, s, bc, rr);
      model_hi = eh; model_lo = el;
      total_cnt++;
      if (bc !== W || done !== 1'b1 || hi !== eh || lo !== el)
        $display("FAIL rand_seq op%0d a=%h b=%h s=%b busy=%0d done=%b hi=%h lo=%h required %0d/1/%h/%h",
                 op, a, b, s, bc, done, hi, lo, W, eh, el);
      else pass_cnt++;
    end
  endtask

  task automatic test_move(input logic [3:0] op, input logic [W-1:0] a);
    logic [W-1:0] eh, el;
    model_md(op, a, 32'h0, 1'b0, eh, el);
    model_hi = eh; model_lo = el;
    @(posedge clk); #1;
    ALUop = op; ope1 = a; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; ALUop = 4'b1110;
    total_cnt++;
    if (hi !== eh || lo !== el || busy !== 1'b0 || done !== 1'b0)
      $display("FAIL move_op%0d hi=%h lo=%h busy=%b done=%b required %h/%h/0/0", op, hi, lo, busy, done, eh, el);
    else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++;
    if (busy !== 1'b0 || done !== 1'b0) $display("FAIL move_nodone op%0d busy=%b done=%b required 0/0", op, busy, done);
    else pass_cnt++;
  endtask

  task automatic test_start_while_busy();
    int bc;
    logic [W-1:0] eh, el;
    model_md(4'b1001, 32'h12345678, 32'h0, 1'b1, eh, el);
    @(posedge clk); #1;
    ALUop = 4'b1001; ope1 = 32'h12345678; ope2 = '0; ALUsign = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    bc = 0;
    while (busy && bc < 200) begin
      bc++;
      start = (bc == 5);
      ALUop = (bc == 5) ? 4'b1000 : 4'b1110;
      ope1 = $urandom; ope2 = $urandom;
      @(posedge clk); #1;
    end
    start = 1'b0; ALUop = 4'b1110;
    model_hi = eh; model_lo = el;
    total_cnt++;
    if (bc !== W || done !== 1'b1 || hi !== eh || lo !== el)
      $display("FAIL div0_restart busy=%0d done=%b hi=%h lo=%h required %0d/1/%h/%h", bc, done, hi, lo, W, eh, el);
    else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL ignored_start busy=%b required 0", busy);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int bc;
    logic [W-1:0] rr, eh, el, a, b;
    a = $urandom; b = $urandom;
    @(posedge clk); #1;
    do_seq(4'b1000, 32'd1000, 32'd3, 1'b0, bc, rr);
    model_hi = 32'd0; model_lo = 32'd3000;
    model_md(4'b1001, a, b, 1'b1, eh, el);
    // already in the done cycle: start again immediately
    do_seq(4'b1001, a, b, 1'b1, bc, rr);
    model_hi = eh; model_lo = el;
    total_cnt++;
    if (rr !== 32'd0 || bc !== W || done !== 1'b1 || hi !== eh || lo !== el)
      $display("FAIL back_to_back mfhi=%h busy=%0d done=%b hi=%h lo=%h required 0/%0d/1/%h/%h", rr, bc, done, hi, lo, W, eh, el);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_run();
    int seen;
    test_move(4'b1010, 32'hDEADBEEF);
    ALUop = 4'b1000; ope1 = 32'hFFFFFFFD; ope2 = 32'd5; ALUsign = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; ALUop = 4'b1110;
    repeat (9) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    model_hi = '0; model_lo = '0;
    total_cnt++;
    if (busy !== 1'b0 || done !== 1'b0 || hi !== '0 || lo !== '0)
      $display("FAIL reset_mid_run busy=%b done=%b hi=%h lo=%h required 0/0/0/0", busy, done, hi, lo);
    else pass_cnt++;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (done || busy) seen++;
      @(posedge clk); #1;
    end
    total_cnt++;
    if (seen !== 0) $display("FAIL no_done_after_reset active_cycles=%0d required 0", seen);
    else pass_cnt++;
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_add_overflow();
    test_alu_random();
    test_seq_fixed(4'b1000, 32'hFFFFFFFD, 32'd5, 1'b1);
    test_seq_fixed(4'b1000, 32'hFFFFFFFF, 32'd2, 1'b0);
    test_seq_fixed(4'b1001, 32'hFFFFFFF9, 32'd2, 1'b1);
    test_seq_fixed(4'b1001, 32'h80000000, 32'hFFFFFFFF, 1'b1);
    test_seq_random();
    test_start_while_busy();
    test_move(4'b1011, 32'hA5A5A5A5);
    test_move(4'b1010, 32'h3C3C0F0F);
    test_alu_random();
    test_back_to_back();
    test_reset_mid_run();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/alu_md.md
Name: alu_md

Overview:
- Parametrised next-generation execute unit for the MIPS-lite datapath. Combines the single-cycle integer ALU with an iterative multiply/divide unit and architectural HI/LO registers.
- Extends the ALU op set: AND/XOR/NOR/SLTU, and add/sub overflow detection.
- Adds a start/busy/done handshake so the pipeline controller can stall on MULT/DIV.
- Sits in the EX stage, between the operand muxes and the EX/MEM register.

Parameters:
WIDTH  32  datapath width; ope1, ope2, result, hi, lo are all WIDTH bits; must be >= 4.
CNT_W  6  iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
ope1  in  WIDTH  operand A (rs); dividend / multiplicand
ope2  in  WIDTH  operand B (rt/imm); divisor / multiplier
ALUop  in  4  operation select
ALUsign  in  1  1 = signed semantics (add/sub overflow, slt, mult, div)
start  in  1  one-cycle request for sequential ops (ALUop 1000..1011)
result  out  WIDTH  combinational ALU result
zero  out  1  (result == 0)
overflow  out  1  signed add/sub overflow
busy  out  1  multi-cycle operation in progress
done  out  1  one-cycle pulse: hi/lo just updated by MULT/DIV
hi  out  WIDTH  HI register
lo  out  WIDTH  LO register

Behaviour:
- Reset (synchronous, active-high): hi=0, lo=0, busy=0, done=0, FSM=IDLE, counter=0. Reset wins over everything, including mid-operation; any partial product or quotient is discarded.
- Combinational ops, result valid in the same cycle, independent of FSM state:
  - 0000 add; 0001 sub; 0010 or; 0011 slt (signed if ALUsign, else unsigned; result is 0 or 1, zero-extended); 0100 and; 0101 xor; 0110 nor.
  - 1100 mfhi (result=hi); 1101 mflo (result=lo).
  - 1000..1011, 1110, 1111: result=0.
- result is fully assigned for every op; no latches.
- overflow = ALUsign & op is add/sub & signed overflow. Sub overflow uses the sign of ~ope2; the wrapped result is still driven. overflow=0 for all other ops.
- Sequential ops, sampled only when start=1 and FSM is IDLE:
  - 1000 mult; 1001 div; 1010 mthi (hi<=ope1 at that edge, busy stays 0, no done); 1011 mtlo (lo<=ope1, likewise).
- start while busy: ignored, no state change. start with a non-sequential ALUop: ignored.
- FSM states:
  - IDLE: on start with mult/div, latch operand magnitudes (signed mode: absolute values; record result signs), counter=0, go RUN.
  - RUN: one shift-add (mult) or restoring shift-subtract (div) step per cycle. When counter==WIDTH-1: write hi/lo with sign correction applied, go IDLE, assert done next cycle.
- Timing:
  - busy = (FSM==RUN); high for exactly WIDTH cycles, starting the cycle after the accepted start edge.
  - done is registered, high for the one cycle after busy falls. hi/lo hold new values in that same cycle.
  - A new start in the done cycle is accepted.
- Arithmetic results:
  - mult: {hi,lo} = full 2*WIDTH product (signed or unsigned).
  - div: lo = quotient truncated toward zero; hi = remainder, sign follows dividend.
  - Divide by zero: lo = all ones, hi = ope1 (unsigned magnitude path with sign fixup skipped). Completes in WIDTH cycles like any divide.
  - Signed most-negative / -1: lo = most-negative, hi = 0. No trap.
- Operand inputs may change during RUN; the latched copies are used.
- mfhi/mflo during RUN return the old hi/lo.

Test Plan:
- WIDTH=32, ALUsign=1, add 0x7FFFFFFF+0x00000001 -> result=0x80000000, overflow=1, zero=0. Same with ALUsign=0 -> overflow=0.
- Signed mult, start with ope1=0xFFFFFFFD (-3), ope2=5:
  - busy high exactly 32 cycles.
  - then done=1 for 1 cycle with hi=0xFFFFFFFF, lo=0xFFFFFFF1.
  - mflo afterwards -> result=0xFFFFFFF1.
- Unsigned mult 0xFFFFFFFF*2 -> hi=0x00000001, lo=0xFFFFFFFE. Signed div -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- Div by zero, ope1=0x12345678, ope2=0 -> lo=0xFFFFFFFF, hi=0x12345678. Second start issued mid-RUN -> ignored, busy length unchanged.
- Start mult, assert reset at RUN cycle 10 -> next cycle busy=0, done=0, hi=lo=0, and no done pulse follows. mtlo ope1=0xA5A5A5A5 while idle -> lo=0xA5A5A5A5 next cycle, busy stays 0.
